sd_rrarb_iofull: RTL and testbench
==================================

# sd_rrarb_iofull

Round-robin arbiter that shares one registered srdy/drdy output channel between `inputs` requesters, with optional packet locking. It sits where several producer streams merge onto one shared pipeline resource. It owns the arbitration state and a 2-entry output skid buffer, so `p_srdy` is driven straight from a flop and a full-throughput stream is sustained at one beat per cycle.

## Interface
- `inputs`, 4: number of requesters, 2..16.
- `width`, 8: data bits per beat.
- `lock_mode`, 1: 1 = hold the grant until the end-of-packet beat; 0 = rearbitrate on every beat.
- `gw`, $clog2(inputs): grant-index width. Derived; do not override.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low. 0 = reset asserted.
- `c_srdy`  in  inputs  per-requester valid.
- `c_drdy`  out  inputs  per-requester ready; at most one bit is high.
- `c_data`  in  inputs*width  requester i occupies bits [i*width +: width].
- `c_eop`  in  inputs  per-requester end-of-packet flag.
- `p_srdy`  out  1  output valid, driven from a flop.
- `p_drdy`  in  1  output ready.
- `p_data`  out  width  data of the head beat.
- `p_grant`  out  gw  source index of the head beat.
- `p_eop`  out  1  eop of the head beat.

## Operation
- **Buffer.** Two entries, each holding {data, grant, eop}, with occupancy `count` in 0..2.
  - push = |(c_srdy & c_drdy); pop = p_srdy & p_drdy.
  - count_next = count + push − pop.
  - The buffer is strictly FIFO. The head is the oldest beat.
- **Output flags.**
  - `p_srdy` is a flop equal to (count != 0).
  - `room` is a flop equal to (count < 2).
  - Both flags are updated from count_next.
- **Pointer.** `ptr` (gw bits) is the last-granted index. Reset value: inputs−1.
- **Grant, unlocked.**
  - Search from ptr+1 upward, wrapping modulo `inputs`.
  - The first i with c_srdy[i]=1 wins.
  - c_drdy[i] = room & win[i]. All other bits are 0.
- **Pointer update.** On push, ptr := winner index. With no push, ptr holds.
- **Lock** (`lock_mode`=1 only).
  - A pushed beat with c_eop=0 sets `locked`=1 and `lock_idx`=source.
  - While locked, only c_drdy[lock_idx] may assert, even if that requester is idle and others request.
  - A pushed beat with c_eop=1 from lock_idx clears `locked`.
  - When `lock_mode`=0, `locked` stays 0 permanently.
- **Combinational paths.** `c_drdy` depends combinationally only on c_srdy, ptr, locked, lock_idx and room. There is no path from `p_drdy` to `c_drdy`.
- **Reset** (sampled with reset=0). It has the same effect mid-operation:
  - count=0, p_srdy=0, room=1, ptr=inputs−1, locked=0.
  - Buffered beats are discarded.
  - c_drdy=0 during any cycle in which reset=0.
  - p_data, p_grant and p_eop are don't-care while p_srdy=0.
- **Illegal use.** Changing c_data, c_eop or deasserting c_srdy before acceptance violates the protocol. The block need not detect it.

## Timing
- **Latency.** A beat accepted at edge N is presented on p_data/p_grant/p_eop with p_srdy=1 after edge N.
- **Throughput.** With p_drdy held at 1, one beat passes per cycle; count stays at 1 and room stays at 1.
- **Backpressure.**
  - p_drdy=0 with count=1 and a push gives count=2; room falls after that edge, so c_drdy=0 the next cycle.
  - The second entry absorbs the beat that was already granted in the cycle p_drdy fell.
- **Recovery from full.** count=2 with a pop gives count=1; room rises after that edge, so there is one bubble cycle on the input side.
- **Simultaneous events.** Push and pop in the same cycle at count=1 or count=2 leave count unchanged and keep order.
- **First cycle after reset.** With reset=1, c_drdy may assert on the first cycle after reset.

## Test plan
1. **Fairness.** inputs=4, lock_mode=0, all c_srdy held at 1, p_drdy=1 → p_grant sequence 0,1,2,3,0,… with p_srdy continuously 1 from the second cycle.
2. **Sparse requests.** Only c_srdy[2] and c_srdy[3] held at 1 with ptr=inputs−1 → grants alternate 2,3,2,3. c_drdy[0] and c_drdy[1] are never 1.
3. **Backpressure.** Single requester streaming data 1,2,3,…; p_drdy=0 for 3 cycles, then 1 → exactly 2 beats buffered, c_drdy low during the stall, and the output is 1,2,3,4,… with no loss or duplication.
4. **Packet lock.**
   - Stimulus: lock_mode=1; requester 1 sends 3 beats (eop on the 3rd) with a one-cycle gap after beat 1; requester 0 requests throughout.
   - Required: requester 0 is not granted until after requester 1's eop beat; p_grant reads 1,1,1,0.
5. **Mid-stream reset.** reset=0 for one cycle while count=2 and locked=1 → next cycle p_srdy=0, no stale beats emitted, and the first grant goes to the lowest requesting index starting from 0.
6. **Random soak.** Random c_srdy, p_drdy and c_eop → scoreboard matches every beat with its source, per-source order is preserved, onehot0(c_drdy) holds, and no requester waits more than inputs−1 grants (lock_mode=0).

Source files
------------

// File: rtl/sd_rrarb_iofull.sv
// sd_rrarb_iofull: round-robin merge of N srdy/drdy streams
// onto one registered output channel with a 2-entry skid buffer.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-low reset
//   c_srdy/c_drdy  per-requester valid / ready (drdy onehot0)
//   c_data/c_eop   per-requester beat data and end-of-packet
//   p_srdy/p_drdy  output valid (flop) / output ready
//   p_data/p_grant head beat data and its source index
//   p_eop          head beat end-of-packet
module sd_rrarb_iofull #(
  parameter int inputs    = 4,
  parameter int width     = 8,
  parameter bit lock_mode = 1'b1,
  parameter int gw        = $clog2(inputs)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [inputs-1:0]       c_srdy,
  output logic [inputs-1:0]       c_drdy,
  input  logic [inputs*width-1:0] c_data,
  input  logic [inputs-1:0]       c_eop,
  output logic                    p_srdy,
  input  logic                    p_drdy,
  output logic [width-1:0]        p_data,
  output logic [gw-1:0]           p_grant,
  output logic                    p_eop
);

  typedef struct packed {
    logic [width-1:0] d;
    logic [gw-1:0]    g;
    logic             e;
  } beat_t;

  logic [1:0]    r_count;
  logic          r_psrdy;
  logic          r_room;
  logic [gw-1:0] r_ptr;
  logic          r_locked;
  logic [gw-1:0] r_lidx;
  beat_t         r_buf [2];

  logic          w_rr_found;
  logic [gw-1:0] w_rr_idx;
  logic [gw-1:0] w_cand;
  logic          w_win_found;
  logic [gw-1:0] w_win_idx;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_cnt_nxt;
  logic          w_slot;
  beat_t         w_in;

  // Rotating priority: first requester above the last winner.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = r_ptr;
    w_cand     = r_ptr;
    for (int k = 1; k <= inputs; k++) begin
      w_cand = gw'((int'(r_ptr) + k) % inputs);
      if (!w_rr_found && c_srdy[w_cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_cand;
      end
    end
  end

  // A held lock pins the grant even when its owner is idle.
  always_comb begin
    w_win_found = w_rr_found;
    w_win_idx   = w_rr_idx;
    if (r_locked) begin
      w_win_found = c_srdy[r_lidx];
      w_win_idx   = r_lidx;
    end
  end

  always_comb begin
    c_drdy = '0;
    if (reset && r_room && w_win_found)
      c_drdy[w_win_idx] = 1'b1;
  end

  always_comb begin
    w_in = '0;
    for (int i = 0; i < inputs; i++) begin
      if (w_win_idx == gw'(i)) begin
        w_in.d = c_data[i*width +: width];
        w_in.e = c_eop[i];
      end
    end
    w_in.g = w_win_idx;
  end

  assign w_push    = |(c_srdy & c_drdy);
  assign w_pop     = r_psrdy & p_drdy;
  assign w_cnt_nxt = r_count + 2'(w_push) - 2'(w_pop);
  // Entry a pushed beat lands in once any pop has shifted.
  assign w_slot    = ((r_count - 2'(w_pop)) != 2'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count  <= 2'd0;
      r_psrdy  <= 1'b0;
      r_room   <= 1'b1;
      r_ptr    <= gw'(inputs - 1);
      r_locked <= 1'b0;
      r_lidx   <= '0;
    end else begin
      r_count <= w_cnt_nxt;
      r_psrdy <= (w_cnt_nxt != 2'd0);
      r_room  <= (w_cnt_nxt != 2'd2);
      if (w_push) begin
        r_ptr <= w_win_idx;
        if (lock_mode) begin
          if (!w_in.e) begin
            r_locked <= 1'b1;
            r_lidx   <= w_win_idx;
          end else begin
            r_locked <= 1'b0;
          end
        end
      end
    end
  end

  // Head is entry 0; a pop shifts entry 1 down.
  always_ff @(posedge clk) begin
    if (w_pop)
      r_buf[0] <= r_buf[1];
    if (w_push) begin
      if (w_slot)
        r_buf[1] <= w_in;
      else
        r_buf[0] <= w_in;
    end
  end

  assign p_srdy  = r_psrdy;
  assign p_data  = r_buf[0].d;
  assign p_grant = r_buf[0].g;
  assign p_eop   = r_buf[0].e;

endmodule

// File: tb/tb_sd_rrarb_iofull.sv
// tb_sd_rrarb_iofull: vectors, corner sequences and a
// queue-based reference model for sd_rrarb_iofull.
module tb_sd_rrarb_iofull;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   c_srdy = '0;
  logic [N-1:0]   c_drdy;
  logic [N-1:0]   c_eop = '1;
  logic [W-1:0]   cd [N];
  logic [N*W-1:0] c_data;
  logic           p_srdy;
  logic           p_drdy = 1'b0;
  logic [W-1:0]   p_data;
  logic [1:0]     p_grant;
  logic           p_eop;

  always #5 clk = ~clk;
  always_comb c_data = {cd[3], cd[2], cd[1], cd[0]};

  sd_rrarb_iofull #(.inputs(N), .width(W), .lock_mode(1'b1)) dut (
    .clk(clk), .reset(rst_n),
    .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data), .c_eop(c_eop),
    .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data),
    .p_grant(p_grant), .p_eop(p_eop)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] d;
    logic [1:0] g;
    logic       e;
  } beat_t;

  beat_t q[$];
  int    m_ptr = N - 1;
  bit    m_locked = 1'b0;
  int    m_lidx = 0;

  logic [N-1:0] o_drdy;
  logic         o_psrdy, o_pop, o_peop;
  logic [7:0]   o_pdata;
  logic [1:0]   o_pgrant;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Round robin from the last grant, or the lock owner only.
  function automatic logic [N-1:0] m_arb(input logic room);
    logic [N-1:0] r;
    r = '0;
    if (!rst_n || !room) return r;
    if (m_locked) begin
      if (c_srdy[m_lidx]) r[m_lidx] = 1'b1;
      return r;
    end
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (c_srdy[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // One clock: sample at negedge, check, advance model.
  task automatic step();
    beat_t b, h;
    logic [N-1:0] xd;
    int src;
    @(negedge clk);
    o_drdy   = c_drdy;
    o_psrdy  = p_srdy;
    o_pdata  = p_data;
    o_pgrant = p_grant;
    o_peop   = p_eop;
    o_pop    = p_srdy & p_drdy;
    xd = m_arb(q.size() < 2);
    chk("c_drdy", int'(o_drdy), int'(xd));
    chk("onehot0", int'($onehot0(o_drdy)), 1);
    if (rst_n) begin
      chk("p_srdy", int'(o_psrdy), int'(q.size() != 0));
      if (q.size() != 0) begin
        chk("p_data", int'(o_pdata), int'(q[0].d));
        chk("p_grant", int'(o_pgrant), int'(q[0].g));
        chk("p_eop", int'(o_peop), int'(q[0].e));
      end
    end
    if (!rst_n) begin
      q.delete();
      m_ptr = N - 1;
      m_locked = 1'b0;
    end else begin
      if (q.size() != 0 && p_drdy) h = q.pop_front();
      if ((c_srdy & xd) != '0) begin
        src = 0;
        for (int i = 0; i < N; i++) if (xd[i]) src = i;
        b.d = cd[src];
        b.g = 2'(src);
        b.e = c_eop[src];
        q.push_back(b);
        m_ptr = src;
        if (!b.e) begin
          m_locked = 1'b1;
          m_lidx = src;
        end else begin
          m_locked = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    c_srdy = '0;
    c_eop = '1;
    p_drdy = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] srdy;
    logic       pdr;
    logic [3:0] xd;
    logic       xps;
    logic [1:0] xg;
    logic       ck;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [3:0] s,
                              input logic pdr, input logic [3:0] xd,
                              input logic xps, input logic [1:0] xg,
                              input logic ck);
    vec_t v;
    v.rst = rst; v.srdy = s; v.pdr = pdr; v.xd = xd;
    v.xps = xps; v.xg = xg; v.ck = ck;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[$];
    logic [1:0] gq[$];
    logic [5:0] sin [N];
    logic [5:0] sout [N];
    int wt [N];
    bit pend [N];
    int nd, eo;

    for (int i = 0; i < N; i++) cd[i] = 8'(8'hA0 + i);
    rst_n = 1'b0;
    step();
    step();

    // fairness: all request, grants 0,1,2,3,0,1
    tv.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
    tv.push_back(mk(1, 4'b1111, 1, 4'b0001, 0, 0, 1));
    tv.push_back(mk(1, 4'b1111, 1, 4'b0010, 1, 0, 1));
    tv.push_back(mk(1, 4'b1111, 1, 4'b0100, 1, 1, 1));
    tv.push_back(mk(1, 4'b1111, 1, 4'b1000, 1, 2, 1));
    tv.push_back(mk(1, 4'b1111, 1, 4'b0001, 1, 3, 1));
    tv.push_back(mk(1, 4'b1111, 1, 4'b0010, 1, 0, 1));
    tv.push_back(mk(1, 4'b1111, 1, 4'b0100, 1, 1, 1));
    // sparse: only 2 and 3 request after reset
    tv.push_back(mk(0, 4'b1100, 1, 4'b0000, 0, 0, 0));
    tv.push_back(mk(1, 4'b1100, 1, 4'b0100, 0, 0, 1));
    tv.push_back(mk(1, 4'b1100, 1, 4'b1000, 1, 2, 1));
    tv.push_back(mk(1, 4'b1100, 1, 4'b0100, 1, 3, 1));
    tv.push_back(mk(1, 4'b1100, 1, 4'b1000, 1, 2, 1));
    tv.push_back(mk(1, 4'b1100, 1, 4'b0100, 1, 3, 1));
    tv.push_back(mk(1, 4'b1100, 1, 4'b1000, 1, 2, 1));

    c_eop = '1;
    for (int n = 0; n < tv.size(); n++) begin
      rst_n = tv[n].rst;
      c_srdy = tv[n].srdy;
      p_drdy = tv[n].pdr;
      step();
      chk($sformatf("tv%0d_drdy", n), int'(o_drdy), int'(tv[n].xd));
      if (tv[n].ck) begin
        chk($sformatf("tv%0d_psrdy", n), int'(o_psrdy), int'(tv[n].xps));
        if (tv[n].xps)
          chk($sformatf("tv%0d_grant", n), int'(o_pgrant), int'(tv[n].xg));
      end
    end

    // backpressure: requester 0 streams 1..10
    do_reset();
    nd = 1;
    eo = 1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      c_srdy = (nd <= 10) ? 4'b0001 : 4'b0000;
      cd[0] = 8'(nd);
      p_drdy = (cyc >= 1 && cyc <= 3) ? 1'b0 : 1'b1;
      step();
      if (cyc == 1) chk("bp_absorb", int'(o_drdy), 1);
      if (cyc >= 2 && cyc <= 4) chk("bp_stall", int'(o_drdy), 0);
      if (cyc == 3) chk("bp_full_psrdy", int'(o_psrdy), 1);
      if (cyc == 5) chk("bp_resume", int'(o_drdy), 1);
      if (o_drdy[0] && c_srdy[0]) nd++;
      if (o_pop) begin
        chk("bp_order", int'(o_pdata), eo);
        eo++;
      end
    end
    chk("bp_count", eo, 11);

    // packet lock: prime ptr to 0, then 1 sends 3 beats
    do_reset();
    p_drdy = 1'b1;
    c_eop = 4'b1111;
    c_srdy = 4'b0001;
    cd[0] = 8'h30;
    step();
    chk("lk_prime", int'(o_drdy), 1);
    c_srdy = 4'b0011;
    cd[0] = 8'h31;
    cd[1] = 8'h41;
    c_eop = 4'b1101;
    step();
    chk("lk_b1", int'(o_drdy), 2);
    for (int s = 0; s < 7; s++) begin
      case (s)
        0: c_srdy = 4'b0001;
        1: begin c_srdy = 4'b0011; cd[1] = 8'h42; c_eop = 4'b1101; end
        2: begin cd[1] = 8'h43; c_eop = 4'b1111; end
        3: c_srdy = 4'b0001;
        default: c_srdy = 4'b0000;
      endcase
      step();
      if (s == 0) chk("lk_gap", int'(o_drdy), 0);
      if (s == 1) chk("lk_b2", int'(o_drdy), 2);
      if (s == 2) chk("lk_b3", int'(o_drdy), 2);
      if (s == 3) chk("lk_r0", int'(o_drdy), 1);
      if (o_pop) gq.push_back(o_pgrant);
    end
    chk("lk_ngrant", gq.size(), 4);
    if (gq.size() == 4) begin
      chk("lk_g0", int'(gq[0]), 1);
      chk("lk_g1", int'(gq[1]), 1);
      chk("lk_g2", int'(gq[2]), 1);
      chk("lk_g3", int'(gq[3]), 0);
    end

    // mid-stream reset with count=2 and lock held
    do_reset();
    p_drdy = 1'b0;
    c_srdy = 4'b0010;
    c_eop = 4'b1101;
    cd[1] = 8'hE1;
    step();
    cd[1] = 8'hE2;
    step();
    chk("mr_fill", int'(o_drdy), 2);
    rst_n = 1'b0;
    c_srdy = 4'b1010;
    cd[3] = 8'h77;
    step();
    chk("mr_rst_drdy", int'(o_drdy), 0);
    rst_n = 1'b1;
    cd[1] = 8'h55;
    c_eop = 4'b1111;
    step();
    chk("mr_psrdy", int'(o_psrdy), 0);
    chk("mr_first", int'(o_drdy), 2);
    c_srdy = 4'b1000;
    p_drdy = 1'b1;
    step();
    chk("mr_head_v", int'(o_psrdy), 1);
    chk("mr_head_g", int'(o_pgrant), 1);
    chk("mr_head_d", int'(o_pdata), 8'h55);
    c_srdy = 4'b0000;
    step();
    step();

    // random soak: phase 0 no eop gaps (fairness), phase 1 locks
    do_reset();
    for (int i = 0; i < N; i++) begin
      sin[i] = '0;
      sout[i] = '0;
      wt[i] = 0;
      pend[i] = 1'b0;
    end
    for (int ph = 0; ph < 2; ph++) begin
      for (int cyc = 0; cyc < 1500; cyc++) begin
        for (int i = 0; i < N; i++) begin
          if (!pend[i] && $urandom_range(0, 99) < 60) begin
            pend[i] = 1'b1;
            cd[i] = {2'(i), sin[i]};
            c_eop[i] = (ph == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
          end
          c_srdy[i] = pend[i];
        end
        p_drdy = ($urandom_range(0, 99) < 70);
        step();
        for (int j = 0; j < N; j++) begin
          if (o_drdy[j] && c_srdy[j]) begin
            if (ph == 0) begin
              chk("fair_wait", int'(wt[j] <= N - 1), 1);
              for (int i = 0; i < N; i++)
                if (i != j && c_srdy[i]) wt[i]++;
            end
            wt[j] = 0;
            pend[j] = 1'b0;
            sin[j] = sin[j] + 6'd1;
          end
        end
        if (o_pop) begin
          chk("src_tag", int'(o_pgrant), int'(o_pdata[7:6]));
          chk("src_order", int'(o_pdata[5:0]), int'(sout[o_pdata[7:6]]));
          sout[o_pdata[7:6]] = o_pdata[5:0] + 6'd1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
